// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM encoding, default program size, buffer entry layout.
package fetch_pkg;

   localparam int PROG_WORDS_DFLT = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetch entries; head is registered storage, visible the cycle after push.
// Latency: 1 cycle push-to-head when empty; flush clears occupancy in one cycle.
// Backpressure: push is accepted only when not full or when a pop happens in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t push_dat,
   input  logic         pop,
   input  logic         flush,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head_dat
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [CW-1:0]  count;
   logic           do_push;
   logic           do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: walks pc over a combinational imem into a 2-entry output buffer.
// Latency: 1 cycle from fetch to out_* when the buffer is empty.
// Backpressure: out_ready=0 fills the buffer, then pc stalls until a pop frees a slot.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int PROG_WORDS = PROG_WORDS_DFLT,
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        out_valid,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   output logic        done
);

   localparam logic [31:0] PC_END = 32'(PROG_WORDS);

   fetch_state_t state;
   logic [31:0]  pc;
   logic         buf_full;
   logic         buf_empty;
   logic         redirect_eff;
   logic         pop;
   logic         fetch;
   fetch_entry_t head;
   fetch_entry_t push_dat;

   // A redirect flushes the buffer, so any handshake in that cycle must not count.
   assign redirect_eff = redirect && (state != ST_IDLE);
   assign pop          = out_valid && out_ready && !redirect_eff;
   assign fetch        = (state == ST_RUN) && (pc < PC_END) && !redirect_eff &&
                         (!buf_full || pop);
   assign push_dat     = '{pc: pc, inst: imem_data};

   assign imem_addr = pc;
   assign out_valid = !buf_empty;
   assign out_inst  = head.inst;
   assign out_pc    = head.pc;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fetch),
      .push_dat (push_dat),
      .pop      (pop),
      .flush    (redirect_eff),
      .full     (buf_full),
      .empty    (buf_empty),
      .head_dat (head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         pc    <= '0;
         done  <= 1'b0;
      end else if (redirect_eff) begin
         state <= ST_RUN;
         pc    <= redirect_target;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) state <= ST_RUN;
            end
            ST_RUN: begin
               if (fetch) pc <= pc + 32'd1;
               if ((pc >= PC_END) && buf_empty) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_DONE;
            end
         endcase
      end
   end

endmodule
